// File: rtl/hilo_md_ctrl.sv
// EX-stage multiply/divide sequencer and owner of the HI/LO registers.
// Multiplies take MUL_LAT cycles; divides run 32 restoring steps before a single commit.
module hilo_md_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [1:0]  ex_hilowen,
  input  logic [1:0]  ex_hiloren,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_hold,
  input  logic        ex_flush,
  output logic        mdu_stall,
  output logic        md_done,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] MUL_CNT0 = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT0 = 5'd31;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r;
  logic [31:0] a_r, b_r;
  logic        sign_r, is_div_r;
  logic [31:0] rem_r, quo_r, dvs_r;
  logic [63:0] prod_r;
  logic [31:0] hi_r, lo_r;

  logic        md_op_s, move_s, commit_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s, step_s, result_s;
  logic [31:0] quo_fix_s, rem_fix_s;

  // Magnitude of an operand; raw value in unsigned mode.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    abs32 = (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // One restoring step: shift the next dividend bit in, subtract when it fits.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] trial;
    trial = {rem, quo[31]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      div_step = {trial[31:0], quo[30:0], 1'b1};
    end else begin
      div_step = {trial[31:0], quo[30:0], 1'b0};
    end
  endfunction

  // Operation decode, datapath arithmetic and final result selection.
  always_comb begin
    md_op_s   = ex_valid && (ex_mult || ex_div);
    move_s    = (state_r == ST_IDLE) && ex_valid && !ex_mult && !ex_div && !ex_hold && !ex_flush;
    commit_s  = (state_r == ST_DONE) && !ex_hold && !ex_flush;
    ext_a_s   = {{32{sign_r & a_r[31]}}, a_r};
    ext_b_s   = {{32{sign_r & b_r[31]}}, b_r};
    prod_s    = ext_a_s * ext_b_s;
    step_s    = div_step(rem_r, quo_r, dvs_r);
    quo_fix_s = (sign_r && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_r) : quo_r;
    rem_fix_s = (sign_r && a_r[31]) ? (32'd0 - rem_r) : rem_r;
    if (!is_div_r) begin
      result_s = prod_r;
    end else if (b_r == 32'd0) begin
      result_s = {a_r, 32'hFFFF_FFFF};
    end else begin
      result_s = {rem_fix_s, quo_fix_s};
    end
  end

  // Next-state logic; flush wins in every state, a dropped ex_valid aborts a running op.
  always_comb begin
    state_s = state_r;
    if (ex_flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md_op_s) begin
            state_s = ex_mult ? ST_MUL : ST_DIV;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (!ex_valid) begin
            state_s = ST_IDLE;
          end else if (cnt_r == 5'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = state_r;
          end
        end
        ST_DONE: begin
          if (ex_hold) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration datapath and HI/LO writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r    <= 5'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      sign_r   <= 1'b0;
      is_div_r <= 1'b0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      dvs_r    <= 32'd0;
      prod_r   <= 64'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md_op_s && !ex_flush) begin
            a_r      <= ex_a;
            b_r      <= ex_b;
            sign_r   <= ex_mdsign;
            is_div_r <= !ex_mult;
            cnt_r    <= ex_mult ? MUL_CNT0 : DIV_CNT0;
            rem_r    <= 32'd0;
            quo_r    <= abs32(ex_a, ex_mdsign);
            dvs_r    <= abs32(ex_b, ex_mdsign);
          end
        end
        ST_MUL: begin
          cnt_r  <= cnt_r - 5'd1;
          prod_r <= prod_s;
        end
        ST_DIV: begin
          cnt_r <= cnt_r - 5'd1;
          rem_r <= step_s[63:32];
          quo_r <= step_s[31:0];
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
      if (commit_s) begin
        hi_r <= result_s[63:32];
        lo_r <= result_s[31:0];
      end else if (move_s) begin
        if (ex_hilowen[1]) hi_r <= ex_a;
        if (ex_hilowen[0]) lo_r <= ex_a;
      end
    end
  end

  // Stall, done and read mux are combinational so they drop with flush/reset immediately.
  always_comb begin
    mdu_stall = resetn && !ex_flush &&
                (((state_r == ST_IDLE) && md_op_s) || (state_r == ST_MUL) || (state_r == ST_DIV));
    md_done   = resetn && (state_r == ST_DONE);
    if (!resetn) begin
      hilo_rdata = 32'd0;
    end else if (ex_hiloren[1]) begin
      hilo_rdata = hi_r;
    end else if (ex_hiloren[0]) begin
      hilo_rdata = lo_r;
    end else begin
      hilo_rdata = 32'd0;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: mult/div results, latencies, moves, hold, flush and reset.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0, ex_mult = 1'b0, ex_div = 1'b0, ex_mdsign = 1'b0;
  logic [1:0]  ex_hilowen = 2'b00, ex_hiloren = 2'b00;
  logic [31:0] ex_a = 32'd0, ex_b = 32'd0;
  logic        ex_hold = 1'b0, ex_flush = 1'b0;
  logic        mdu_stall, md_done;
  logic [31:0] hilo_rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_md_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_mult(ex_mult), .ex_div(ex_div),
    .ex_mdsign(ex_mdsign), .ex_hilowen(ex_hilowen), .ex_hiloren(ex_hiloren),
    .ex_a(ex_a), .ex_b(ex_b), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .mdu_stall(mdu_stall), .md_done(md_done), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_valid = 1'b0; ex_mult = 1'b0; ex_div = 1'b0; ex_mdsign = 1'b0;
    ex_hilowen = 2'b00; ex_hiloren = 2'b00; ex_hold = 1'b0; ex_flush = 1'b0;
  endtask

  // Issue an op, count stalled cycles up to DONE, then let it commit.
  task automatic run_op(input string tag, input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                        input logic keep);
    int n;
    ex_valid = 1'b1; ex_mult = m; ex_div = d; ex_mdsign = s;
    ex_a = a; ex_b = b; ex_hilowen = 2'b11;
    #1;
    n = 0;
    while (mdu_stall && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({tag, "_md_done"}, 64'(md_done), 64'd1);
    tick();
    if (!keep) begin
      ex_valid = 1'b0; ex_mult = 1'b0; ex_div = 1'b0;
    end
    #1;
  endtask

  initial begin
    // Reset values, with an md op and a read presented while reset is held.
    ex_valid = 1'b1; ex_mult = 1'b1; ex_hiloren = 2'b11;
    #2;
    chk("rst_stall", 64'(mdu_stall), 64'd0);
    chk("rst_done", 64'(md_done), 64'd0);
    chk("rst_rdata", 64'(hilo_rdata), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    clear_in();
    tick();

    // Signed mult, then an unsigned mult accepted directly after DONE.
    run_op("mult_s", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 3, 1'b1);
    chk("mult_s_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_s_lo", 64'(lo), 64'hFFFF_FFFA);
    chk("b2b_accept_stall", 64'(mdu_stall), 64'd1);
    run_op("multu", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 3, 1'b0);
    chk("multu_hi", 64'(hi), 64'h0000_0002);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    // Divides: signed mixes, overflow case, unsigned, divide by zero.
    run_op("div_m7_2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
    chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op("div_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0);
    run_op("div_7_m2", 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
    chk("div_7_m2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_7_m2_hi", 64'(hi), 64'h1);
    run_op("divu_100_7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 33, 1'b0);
    chk("divu_100_7_lo", 64'(lo), 64'hE);
    chk("divu_100_7_hi", 64'(hi), 64'h2);
    run_op("divu_by0", 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 33, 1'b0);
    chk("divu_by0_hi", 64'(hi), 64'h5);
    chk("divu_by0_lo", 64'(lo), 64'hFFFF_FFFF);
    run_op("div_by0", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 33, 1'b0);
    chk("div_by0_hi", 64'(hi), 64'hFFFF_FFF0);
    chk("div_by0_lo", 64'(lo), 64'hFFFF_FFFF);

    // mthi+mtlo in one op, then flush a div on its 10th cycle.
    ex_valid = 1'b1; ex_hilowen = 2'b11; ex_a = 32'h1111_1111;
    #1;
    chk("mt_both_stall", 64'(mdu_stall), 64'd0);
    tick();
    clear_in();
    #1;
    chk("mt_both_hi", 64'(hi), 64'h1111_1111);
    chk("mt_both_lo", 64'(lo), 64'h1111_1111);
    ex_valid = 1'b1; ex_div = 1'b1; ex_mdsign = 1'b1; ex_a = 32'd100; ex_b = 32'd7;
    ex_hilowen = 2'b11;
    repeat (9) tick();
    chk("flush_pre_stall", 64'(mdu_stall), 64'd1);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", 64'(mdu_stall), 64'd0);
    tick();
    clear_in();
    #1;
    chk("flush_done", 64'(md_done), 64'd0);
    repeat (40) tick();
    chk("flush_hi", 64'(hi), 64'h1111_1111);
    chk("flush_lo", 64'(lo), 64'h1111_1111);
    run_op("post_flush_mult", 1'b1, 1'b0, 1'b1, 32'd7, 32'd6, 3, 1'b0);
    chk("post_flush_hi", 64'(hi), 64'h0);
    chk("post_flush_lo", 64'(lo), 64'h2A);

    // mthi followed by mfhi/mflo reads.
    ex_valid = 1'b1; ex_hilowen = 2'b10; ex_a = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(mdu_stall), 64'd0);
    tick();
    ex_hilowen = 2'b00; ex_hiloren = 2'b10;
    #1;
    chk("mfhi_rdata", 64'(hilo_rdata), 64'h1234_5678);
    ex_hiloren = 2'b01;
    #1;
    chk("mflo_rdata", 64'(hilo_rdata), 64'h2A);
    ex_hiloren = 2'b00;
    #1;
    chk("noread_rdata", 64'(hilo_rdata), 64'h0);
    clear_in();
    tick();

    // multu held in DONE for 4 cycles; written once on release.
    ex_valid = 1'b1; ex_mult = 1'b1; ex_a = 32'h0001_0000; ex_b = 32'h0001_0000;
    ex_hilowen = 2'b11;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_op_stall", 64'(mdu_stall), 64'd1);
      tick();
    end
    chk("hold_done_stall", 64'(mdu_stall), 64'd0);
    ex_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_done", 64'(md_done), 64'd1);
      chk("hold_hi", 64'(hi), 64'h1234_5678);
      chk("hold_lo", 64'(lo), 64'h2A);
    end
    ex_hold = 1'b0;
    tick();
    clear_in();
    #1;
    chk("release_hi", 64'(hi), 64'h1);
    chk("release_lo", 64'(lo), 64'h0);
    chk("release_done", 64'(md_done), 64'd0);

    // Asynchronous reset in the middle of a mult.
    ex_valid = 1'b1; ex_mult = 1'b1; ex_mdsign = 1'b1; ex_a = 32'hFFFF_FFFE; ex_b = 32'd3;
    ex_hiloren = 2'b10;
    tick();
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    chk("arst_stall", 64'(mdu_stall), 64'd0);
    chk("arst_done", 64'(md_done), 64'd0);
    chk("arst_rdata", 64'(hilo_rdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    clear_in();
    tick();
    chk("arst_idle_stall", 64'(mdu_stall), 64'd0);
    chk("arst_idle_done", 64'(md_done), 64'd0);
    run_op("post_rst_mult", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 3, 1'b0);
    chk("post_rst_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("post_rst_lo", 64'(lo), 64'hFFFF_FFFA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and owner of the HI/LO registers, placed in the EX stage.
- Consumes the decoder's mult, div, mdsign, hilowen and hiloren controls together with the rs/rt operand values.
- Stalls the pipeline while an operation is in flight and commits the 64-bit result to HI/LO.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
MUL_LAT, 2, cycles spent in the MUL state (≥1); models a pipelined multiplier.

Ports:
clk  input  1  core clock, rising edge
resetn  input  1  asynchronous active-low reset
ex_valid  input  1  valid instruction in EX
ex_mult  input  1  mult/multu in EX
ex_div  input  1  div/divu in EX
ex_mdsign  input  1  1 = signed mult/div
ex_hilowen  input  2  [1] write HI, [0] write LO (mthi/mtlo; 2'b11 with mult/div)
ex_hiloren  input  2  [1] read HI, [0] read LO
ex_a  input  32  GPR[rs]
ex_b  input  32  GPR[rt]
ex_hold  input  1  downstream stall; EX must not advance
ex_flush  input  1  exception/eret flush of EX
mdu_stall  output  1  hold EX (and earlier stages)
md_done  output  1  result valid (state DONE)
hilo_rdata  output  32  hiloren[1] ? HI : LO; 0 if hiloren == 0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: asynchronous on resetn low. State IDLE, hi = lo = 0, counters 0. mdu_stall, md_done and hilo_rdata are 0 while resetn is low.
- md_op = ex_valid && (ex_mult || ex_div).
- IDLE:
  - If md_op && !ex_flush, latch operands and sign mode.
  - mult → MUL with cnt = MUL_LAT-1.
  - div → DIV with cnt = 31.
- MUL: product = 64-bit signed or unsigned a×b. Decrement cnt; at cnt == 0 → DONE.
- DIV: radix-2 restoring divide on |a| and |b| (raw values when unsigned), one quotient bit per cycle, 32 cycles; at cnt == 0 → DONE.
  - Signed fix-up: quotient is negated if a[31]^b[31]; remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0.
  - Divide by zero (either sign mode) gives HI = a, LO = 0xFFFFFFFF; it still takes 32 cycles.
- DONE:
  - md_done = 1, mdu_stall = 0.
  - If !ex_hold && !ex_flush: HI ← result[63:32] (remainder for div), LO ← result[31:0] (quotient for div), → IDLE.
  - If ex_hold: stay in DONE, no write; the result is written exactly once, on release.
- mdu_stall = resetn && !ex_flush && ((state == IDLE && md_op) || state == MUL || state == DIV). It is combinational.
- Latency (EX cycles, no hold):
  - mult: MUL_LAT+2 cycles, of which MUL_LAT+1 are stalled.
  - div: 34 cycles, of which 33 are stalled.
- mthi/mtlo: in IDLE, when ex_valid && !ex_mult && !ex_div && !ex_hold && !ex_flush, write hi/lo ← ex_a per ex_hilowen at the clock edge. No stall.
- Reads: hilo_rdata is combinational from the registers. A read in the cycle after mthi/mtlo, mult or div completion sees the new value; no bypass is needed.
- Flush: ex_flush in any state forces → IDLE next edge. No HI/LO write; mdu_stall drops in the same cycle.
- Abort: if ex_valid falls while in MUL or DIV, → IDLE with no write.
- An md op arriving in the cycle directly after DONE→IDLE is accepted normally (back-to-back operations).
- Operand registers are sampled only on acceptance; changes on ex_a/ex_b mid-operation are ignored.

Test Plan:
- Signed mult: mult a=0xFFFFFFFE, b=3, MUL_LAT=2 → mdu_stall high 3 cycles, md_done on the 4th cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult: multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA. A back-to-back mult starts in the cycle after DONE.
- Signed div:
  - div -7/2 → mdu_stall high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: divu a=5, b=0 → HI=5, LO=0xFFFFFFFF. Signed div a=0xFFFFFFF0, b=0 → HI=0xFFFFFFF0, LO=0xFFFFFFFF.
- Flush mid-div: pulse ex_flush on cycle 10 of a div with HI=LO=0x11111111 → mdu_stall 0 that cycle, state IDLE, HI/LO unchanged. A following mult completes correctly.
- Move and hold:
  - mthi 0x12345678 followed by mfhi → hilo_rdata = 0x12345678 on the next cycle, no stall.
  - Hold ex_hold for 4 cycles during DONE of a multu 0x10000×0x10000 → HI/LO unchanged while held; HI=1, LO=0 written once after release.
- Async reset: assert resetn low in the middle of a mult → hi=lo=0 and mdu_stall=0 immediately. After release, state is IDLE.
